// File: rtl/quick_spi_pkg.sv
// Shared types and constants for the quick SPI master.
// Covers the frame state machine, operation codes and the word bit-ordering rule.
package quick_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ,
        DONE
    } state_e;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam int BYTES_LITTLE_ENDIAN = 0;
    localparam int BYTES_BIG_ENDIAN    = 1;
    localparam int BITS_LSB_FIRST      = 0;
    localparam int BITS_MSB_FIRST      = 1;

    // Word bit position of the seq-th bit on the wire, for a word of 'width' bits.
    function automatic int bit_position(input int seq, input int width,
                                        input int bytes_order, input int bits_order);
        int byte_sel;
        int bit_sel;
        byte_sel = seq / 8;
        bit_sel  = seq % 8;
        if (bytes_order == BYTES_BIG_ENDIAN) begin
            byte_sel = (width / 8) - 1 - byte_sel;
        end
        if (bits_order == BITS_MSB_FIRST) begin
            bit_sel = 7 - bit_sel;
        end
        return (byte_sel * 8) + bit_sel;
    endfunction

endpackage

// File: rtl/quick_spi_bit_index.sv
// Maps a sequential wire bit number to its position inside a WIDTH-bit word,
// honouring byte order and bit-within-byte order. Pure combinational lookup.
module quick_spi_bit_index
    import quick_spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int BYTES_ORDER = 0,
    parameter int BITS_ORDER  = 0,
    localparam int IDX_W      = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] seq,
    output logic [IDX_W-1:0] pos
);

    logic [IDX_W-1:0] map [WIDTH];

    // The table is fully constant; synthesis folds it into a small mux.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_map
        assign map[gi] = IDX_W'(bit_position(gi, WIDTH, BYTES_ORDER, BITS_ORDER));
    end

    assign pos = map[seq];

endmodule

// File: rtl/quick_spi_master.sv
// SPI master: one-hot slave select, fixed-length write and read frames, sclk = clk/2.
// Optional `busy` output is compiled in when QUICK_SPI_BUSY_EN is defined.
module quick_spi_master
    import quick_spi_pkg::*;
#(
    parameter int INCOMING_DATA_WIDTH      = 8,
    parameter int OUTGOING_DATA_WIDTH      = 16,
    parameter bit CPOL                     = 1'b0,
    parameter bit CPHA                     = 1'b0,
    parameter int EXTRA_WRITE_SCLK_TOGGLES = 6,
    parameter int EXTRA_READ_SCLK_TOGGLES  = 4,
    parameter int BYTES_ORDER              = 0,
    parameter int BITS_ORDER               = 0,
    parameter int NUMBER_OF_SLAVES         = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           start_transaction,
    input  logic [NUMBER_OF_SLAVES-1:0]    slave,
    input  logic                           operation,
    output logic                           end_of_transaction,
    output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
    input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
    output logic                           mosi,
    input  logic                           miso,
    output logic                           sclk,
    output logic [NUMBER_OF_SLAVES-1:0]    ss_n
`ifdef QUICK_SPI_BUSY_EN
    ,
    output logic                           busy
`endif
);

    localparam int TX_IDX_W         = $clog2(OUTGOING_DATA_WIDTH);
    localparam int RX_IDX_W         = $clog2(INCOMING_DATA_WIDTH);
    localparam int WR_DATA_TOGGLES  = 2 * OUTGOING_DATA_WIDTH;
    localparam int WR_FRAME_TOGGLES = WR_DATA_TOGGLES + EXTRA_WRITE_SCLK_TOGGLES;
    localparam int RD_DATA_TOGGLES  = 2 * INCOMING_DATA_WIDTH;
    localparam int CNT_W            = $clog2(WR_FRAME_TOGGLES + EXTRA_READ_SCLK_TOGGLES
                                             + RD_DATA_TOGGLES + 2);

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           op_q, op_d;
    logic [OUTGOING_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [INCOMING_DATA_WIDTH-1:0] rx_buf_q, rx_buf_d;
    logic [INCOMING_DATA_WIDTH-1:0] incoming_q, incoming_d;
    logic                           mosi_q, mosi_d;
    logic                           sclk_q, sclk_d;
    logic                           eot_q, eot_d;
    logic [NUMBER_OF_SLAVES-1:0]    ss_n_q, ss_n_d;

    logic [CNT_W-1:0]    tx_bit_num;
    logic                tx_valid;
    logic                shift_edge;
    logic                sample_edge;
    logic [TX_IDX_W-1:0] tx_seq;
    logic [TX_IDX_W-1:0] tx_pos;
    logic [RX_IDX_W-1:0] rx_seq;
    logic [RX_IDX_W-1:0] rx_pos;

    // cnt_q counts toggles within the current phase; even values are leading edges.
    // The bit that follows a shift edge is (cnt+1)/2 for either clock phase.
    assign tx_bit_num  = (cnt_q + CNT_W'(1)) >> 1;
    assign tx_valid    = tx_bit_num < CNT_W'(OUTGOING_DATA_WIDTH);
    assign shift_edge  = CPHA ? (~cnt_q[0] && (cnt_q != '0)) : cnt_q[0];
    assign sample_edge = CPHA ? cnt_q[0] : ~cnt_q[0];
    assign tx_seq      = (state_q == IDLE) ? '0 : tx_bit_num[TX_IDX_W-1:0];
    assign rx_seq      = RX_IDX_W'(cnt_q >> 1);

    quick_spi_bit_index #(
        .WIDTH       (OUTGOING_DATA_WIDTH),
        .BYTES_ORDER (BYTES_ORDER),
        .BITS_ORDER  (BITS_ORDER)
    ) u_tx_index (
        .seq (tx_seq),
        .pos (tx_pos)
    );

    quick_spi_bit_index #(
        .WIDTH       (INCOMING_DATA_WIDTH),
        .BYTES_ORDER (BYTES_ORDER),
        .BITS_ORDER  (BITS_ORDER)
    ) u_rx_index (
        .seq (rx_seq),
        .pos (rx_pos)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        rx_buf_d   = rx_buf_q;
        incoming_d = incoming_q;
        mosi_d     = 1'b0;
        sclk_d     = CPOL;
        ss_n_d     = ss_n_q;
        eot_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                ss_n_d = '1;
                if (start_transaction) begin
                    state_d   = WRITE;
                    cnt_d     = '0;
                    op_d      = operation;
                    tx_data_d = outgoing_data;
                    rx_buf_d  = '0;
                    ss_n_d    = ~slave;
                    mosi_d    = outgoing_data[tx_pos];
                end
            end

            WRITE: begin
                sclk_d = ~sclk_q;
                cnt_d  = cnt_q + CNT_W'(1);
                mosi_d = mosi_q;
                if (shift_edge) begin
                    mosi_d = tx_valid ? tx_data_q[tx_pos] : 1'b0;
                end
                if ((op_q == OP_WRITE) && (cnt_q == CNT_W'(WR_FRAME_TOGGLES - 1))) begin
                    state_d = DONE;
                end else if ((op_q == OP_READ) && (cnt_q == CNT_W'(WR_DATA_TOGGLES - 1))) begin
                    cnt_d   = '0;
                    state_d = (EXTRA_READ_SCLK_TOGGLES == 0) ? READ : READ_WAIT;
                end
            end

            READ_WAIT: begin
                sclk_d = ~sclk_q;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(EXTRA_READ_SCLK_TOGGLES - 1)) begin
                    cnt_d   = '0;
                    state_d = READ;
                end
            end

            READ: begin
                sclk_d = ~sclk_q;
                cnt_d  = cnt_q + CNT_W'(1);
                if (sample_edge) begin
                    rx_buf_d[rx_pos] = miso;
                end
                // With CPHA=1 the last sample lands on this final edge, hence rx_buf_d.
                if (cnt_q == CNT_W'(RD_DATA_TOGGLES - 1)) begin
                    state_d    = DONE;
                    incoming_d = rx_buf_d;
                end
            end

            DONE: begin
                state_d = IDLE;
                ss_n_d  = '1;
            end

            default: begin
                state_d = IDLE;
                ss_n_d  = '1;
            end
        endcase

        if (state_d == DONE) begin
            sclk_d = CPOL;
            mosi_d = 1'b0;
            ss_n_d = '1;
            eot_d  = 1'b1;
        end

        // Abort: drop the frame silently and keep the last good read word.
        if (!enable) begin
            state_d    = IDLE;
            cnt_d      = '0;
            sclk_d     = CPOL;
            mosi_d     = 1'b0;
            ss_n_d     = '1;
            eot_d      = 1'b0;
            incoming_d = incoming_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_WRITE;
            tx_data_q  <= '0;
            rx_buf_q   <= '0;
            incoming_q <= '0;
            mosi_q     <= 1'b0;
            sclk_q     <= CPOL;
            eot_q      <= 1'b0;
            ss_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            rx_buf_q   <= rx_buf_d;
            incoming_q <= incoming_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            eot_q      <= eot_d;
            ss_n_q     <= ss_n_d;
        end
    end

    assign end_of_transaction = eot_q;
    assign incoming_data      = incoming_q;
    assign mosi               = mosi_q;
    assign sclk               = sclk_q;
    assign ss_n               = ss_n_q;

`ifdef QUICK_SPI_BUSY_EN
    // The start cycle is still in IDLE, so busy must look at the request directly.
    assign busy = !reset && ((state_q != IDLE) || (enable && start_transaction));
`endif

endmodule

// File: tb/tb_quick_spi_master.sv
// Directed bench for quick_spi_master: an LE/LSB-first and a BE/MSB-first instance
// share all inputs; frames come from a vector table plus hand-written corner cases.
module tb_quick_spi_master;

    localparam int OW         = 16;
    localparam int IW         = 8;
    localparam int EW         = 6;
    localparam int ER         = 4;
    localparam int WRITE_LEN  = 1 + 2 * OW + EW;
    localparam int READ_LEN   = 1 + 2 * OW + ER + 2 * IW;
    localparam int READ_FIRST = 1 + 2 * OW + ER;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        start_transaction;
    logic        operation;
    logic        miso;
    logic [1:0]  slave;
    logic [15:0] outgoing_data;
    logic        eot_le, eot_be, mosi_le, mosi_be, sclk_le, sclk_be;
    logic [7:0]  rx_le, rx_be;
    logic [1:0]  ss_n_le, ss_n_be;
`ifdef QUICK_SPI_BUSY_EN
    logic        busy_le, busy_be;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        op;
        logic [1:0]  slave;
        logic [15:0] data;
        logic [7:0]  miso_seq;    // wire order, first bit at [7]
        logic [15:0] exp_seq_le;  // wire order, first bit at [15]
        logic [15:0] exp_seq_be;
        logic [1:0]  exp_ss;
        logic [7:0]  exp_rx_le;
        logic [7:0]  exp_rx_be;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    quick_spi_master #(
        .INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW), .CPOL(1'b0), .CPHA(1'b0),
        .EXTRA_WRITE_SCLK_TOGGLES(EW), .EXTRA_READ_SCLK_TOGGLES(ER),
        .BYTES_ORDER(0), .BITS_ORDER(0), .NUMBER_OF_SLAVES(2)
    ) dut_le (
        .clk(clk), .reset(reset), .enable(enable), .start_transaction(start_transaction),
        .slave(slave), .operation(operation), .end_of_transaction(eot_le),
        .incoming_data(rx_le), .outgoing_data(outgoing_data), .mosi(mosi_le),
        .miso(miso), .sclk(sclk_le), .ss_n(ss_n_le)
`ifdef QUICK_SPI_BUSY_EN
        , .busy(busy_le)
`endif
    );

    quick_spi_master #(
        .INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW), .CPOL(1'b0), .CPHA(1'b0),
        .EXTRA_WRITE_SCLK_TOGGLES(EW), .EXTRA_READ_SCLK_TOGGLES(ER),
        .BYTES_ORDER(1), .BITS_ORDER(1), .NUMBER_OF_SLAVES(2)
    ) dut_be (
        .clk(clk), .reset(reset), .enable(enable), .start_transaction(start_transaction),
        .slave(slave), .operation(operation), .end_of_transaction(eot_be),
        .incoming_data(rx_be), .outgoing_data(outgoing_data), .mosi(mosi_be),
        .miso(miso), .sclk(sclk_be), .ss_n(ss_n_be)
`ifdef QUICK_SPI_BUSY_EN
        , .busy(busy_be)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int          len;
        logic [15:0] seq_le;
        logic [15:0] seq_be;
        logic [7:0]  got_rx_le;
        logic [7:0]  got_rx_be;
        bit          ss_ok;
        bit          sclk_ok;
        int          eot_n;
        int          eot_at;
        int          busy_n;
        len       = v.op ? READ_LEN : WRITE_LEN;
        seq_le    = '0;
        seq_be    = '0;
        got_rx_le = '0;
        got_rx_be = '0;
        ss_ok     = 1'b1;
        sclk_ok   = 1'b1;
        eot_n     = 0;
        eot_at    = -1;
        busy_n    = 0;
        @(negedge clk);
        start_transaction = 1'b1;
        operation         = v.op;
        slave             = v.slave;
        outgoing_data     = v.data;
        miso              = 1'b0;
        #1;
`ifdef QUICK_SPI_BUSY_EN
        if (busy_le) busy_n++;
`endif
        @(posedge clk);
        for (int c = 1; c <= len + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Outside IDLE these must be ignored.
                start_transaction = 1'b0;
                operation         = ~v.op;
                slave             = ~v.slave;
                outgoing_data     = ~v.data;
            end
            if (v.op && c >= READ_FIRST && c < READ_FIRST + 2 * IW)
                miso = v.miso_seq[7 - (c - READ_FIRST) / 2];
            else
                miso = 1'b0;
            if (c >= 2 && c <= 2 * OW && (c % 2) == 0) begin
                seq_le[15 - (c - 2) / 2] = mosi_le;
                seq_be[15 - (c - 2) / 2] = mosi_be;
            end
            if (c < len) begin
                if (ss_n_le !== v.exp_ss) ss_ok = 1'b0;
                if (sclk_le !== 1'((c - 1) % 2)) sclk_ok = 1'b0;
            end else if (c == len) begin
                if (ss_n_le !== 2'b11) ss_ok = 1'b0;
                if (sclk_le !== 1'b0) sclk_ok = 1'b0;
                got_rx_le = rx_le;
                got_rx_be = rx_be;
            end
            if (eot_le) begin
                eot_n++;
                eot_at = c;
            end
`ifdef QUICK_SPI_BUSY_EN
            if (busy_le) busy_n++;
`endif
        end
        check("mosi_seq_le", 32'(seq_le), 32'(v.exp_seq_le));
        check("mosi_seq_be", 32'(seq_be), 32'(v.exp_seq_be));
        check("ss_n_frame", 32'(ss_ok), 32'(1));
        check("sclk_frame", 32'(sclk_ok), 32'(1));
        check("eot_count", 32'(eot_n), 32'(1));
        check("eot_cycle", 32'(eot_at), 32'(len));
        if (v.op) begin
            check("rx_le", 32'(got_rx_le), 32'(v.exp_rx_le));
            check("rx_be", 32'(got_rx_be), 32'(v.exp_rx_be));
        end
`ifdef QUICK_SPI_BUSY_EN
        check("busy_cycles", 32'(busy_n), 32'(len + 1));
`endif
        $display("frame op=%0d slave=%b data=%h done@%0d mosi_le=%h mosi_be=%h rx_le=%h rx_be=%h",
                 v.op, v.slave, v.data, eot_at, seq_le, seq_be, got_rx_le, got_rx_be);
    endtask

    initial begin
        int          eot_cycles [3];
        int          n_eot;
        bit          idle_ok;
        logic [7:0]  rx_before;

        vecs[0] = '{op: 1'b0, slave: 2'b01, data: 16'hCC82, miso_seq: 8'h00,
                    exp_seq_le: 16'h4133, exp_seq_be: 16'hCC82, exp_ss: 2'b10,
                    exp_rx_le: 8'h00, exp_rx_be: 8'h00};
        vecs[1] = '{op: 1'b1, slave: 2'b01, data: 16'hCC82, miso_seq: 8'b1010_1001,
                    exp_seq_le: 16'h4133, exp_seq_be: 16'hCC82, exp_ss: 2'b10,
                    exp_rx_le: 8'h95, exp_rx_be: 8'hA9};
        vecs[2] = '{op: 1'b0, slave: 2'b10, data: 16'h1234, miso_seq: 8'h00,
                    exp_seq_le: 16'h2C48, exp_seq_be: 16'h1234, exp_ss: 2'b01,
                    exp_rx_le: 8'h00, exp_rx_be: 8'h00};
        vecs[3] = '{op: 1'b1, slave: 2'b10, data: 16'hA55A, miso_seq: 8'b1111_0000,
                    exp_seq_le: 16'h5AA5, exp_seq_be: 16'hA55A, exp_ss: 2'b01,
                    exp_rx_le: 8'h0F, exp_rx_be: 8'hF0};

        reset             = 1'b1;
        enable            = 1'b1;
        start_transaction = 1'b0;
        operation         = 1'b0;
        slave             = 2'b00;
        outgoing_data     = 16'h0000;
        miso              = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_sclk", 32'(sclk_le), 32'(0));
        check("reset_mosi", 32'(mosi_le), 32'(0));
        check("reset_ss_n", 32'(ss_n_le), 32'(2'b11));
        check("reset_eot", 32'(eot_le), 32'(0));
        check("reset_rx", 32'(rx_le), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Back-to-back: start held, operation flipped at every done pulse.
        n_eot = 0;
        for (int i = 0; i < 3; i++) eot_cycles[i] = -1;
        @(negedge clk);
        start_transaction = 1'b1;
        operation         = 1'b0;
        slave             = 2'b01;
        outgoing_data     = 16'hCC82;
        @(posedge clk);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (eot_le) begin
                if (n_eot < 3) eot_cycles[n_eot] = c;
                n_eot++;
                operation = ~operation;
                if (n_eot == 3) start_transaction = 1'b0;
            end
        end
        check("b2b_count", 32'(n_eot), 32'(3));
        check("b2b_write_done", 32'(eot_cycles[0]), 32'(WRITE_LEN));
        check("b2b_read_done", 32'(eot_cycles[1]), 32'(WRITE_LEN + 1 + READ_LEN));
        check("b2b_write2_done", 32'(eot_cycles[2]), 32'(2 * WRITE_LEN + 2 + READ_LEN));
        $display("back-to-back done pulses at cycles %0d %0d %0d",
                 eot_cycles[0], eot_cycles[1], eot_cycles[2]);

        // Load a known read word so the abort cases can show it is preserved or cleared.
        run_frame(vecs[3]);
        rx_before = 8'h0F;

        // enable dropped in the middle of WRITE.
        @(negedge clk);
        start_transaction = 1'b1;
        operation         = 1'b1;
        slave             = 2'b01;
        outgoing_data     = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        start_transaction = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_abort_ss_n", 32'(ss_n_le), 32'(2'b10));
        enable = 1'b0;
        @(negedge clk);
        check("abort_ss_n", 32'(ss_n_le), 32'(2'b11));
        check("abort_sclk", 32'(sclk_le), 32'(0));
        check("abort_mosi", 32'(mosi_le), 32'(0));
        enable  = 1'b1;
        n_eot   = 0;
        idle_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (eot_le) n_eot++;
            if (ss_n_le !== 2'b11) idle_ok = 1'b0;
        end
        check("abort_no_eot", 32'(n_eot), 32'(0));
        check("abort_stays_idle", 32'(idle_ok), 32'(1));
        check("abort_rx_kept", 32'(rx_le), 32'(rx_before));
        $display("enable-drop frame aborted, rx_le=%h", rx_le);

        // reset asserted in the middle of READ.
        @(negedge clk);
        start_transaction = 1'b1;
        operation         = 1'b1;
        slave             = 2'b10;
        outgoing_data     = 16'h5555;
        miso              = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_transaction = 1'b0;
        repeat (44) @(negedge clk);
        check("pre_reset_ss_n", 32'(ss_n_le), 32'(2'b01));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_ss_n", 32'(ss_n_le), 32'(2'b11));
        check("midreset_sclk", 32'(sclk_le), 32'(0));
        check("midreset_rx", 32'(rx_le), 32'(0));
        n_eot = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (eot_le) n_eot++;
        end
        check("midreset_no_eot", 32'(n_eot), 32'(0));
        $display("reset-mid-read frame cleared, rx_le=%h ss_n=%b", rx_le, ss_n_le);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
